// File: rtl/sdram_pkg.sv
// ============================================================================
//  Module   : sdram_pkg
//  Purpose  : Shared SDRAM definitions. Holds the command enum, the mapping
//             of a command to its {cs_n, ras_n, cas_n, we_n} pin levels, the
//             ns-to-cycles helper and the default mode-register value.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_PRECHARGE,
    CMD_REFRESH,
    CMD_MRS,
    CMD_ACTIVE,
    CMD_READ,
    CMD_WRITE
  } sdram_cmd_t;

  // CAS latency 2, sequential burst, burst length 1.
  localparam logic [10:0] MODE_REG_DEFAULT = 11'h020;

  // Pin levels, ordered {cs_n, ras_n, cas_n, we_n}.
  function automatic logic [3:0] cmd_pins(sdram_cmd_t cmd);
    logic [3:0] pins;
    case (cmd)
      CMD_PRECHARGE: pins = 4'b0010;
      CMD_REFRESH:   pins = 4'b0001;
      CMD_MRS:       pins = 4'b0000;
      CMD_ACTIVE:    pins = 4'b0011;
      CMD_READ:      pins = 4'b0101;
      CMD_WRITE:     pins = 4'b0100;
      default:       pins = 4'b0111;
    endcase
    return pins;
  endfunction

  // Rounds up so a timing minimum is never shortened.
  function automatic int ns_to_cycles(real ns, real clk);
    real cyc;
    int  n;
    cyc = ns * clk * 1.0e-9;
    n   = $rtoi(cyc);
    if ($itor(n) < cyc) n = n + 1;
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_init_sequencer.sv
// ============================================================================
//  Module   : sdram_init_sequencer
//  Purpose  : Issues the SDRAM power-up sequence (PRECHARGE ALL, N x AUTO
//             REFRESH, MODE REGISTER SET) while sdram_init_n is low, then
//             holds init_done. A high on sdram_init_n aborts to idle.
//  Ports    : clk112M       system clock
//             reset_n       asynchronous active-low reset
//             sdram_init_n  low = run/continue, high = abort/idle
//             sdram_cke     clock enable (0 only in reset)
//             sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  command pins
//             sdram_ba      bank address (always 0)
//             sdram_addr    row / mode address
//             init_done     sequence complete
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_init_sequencer
  import sdram_pkg::*;
#(
  parameter real         CLK           = 111857000.0,
  parameter real         T_RP_NS       = 18.0,
  parameter real         T_RFC_NS      = 63.0,
  parameter int          T_MRD_CYC     = 2,
  parameter int          REFRESH_COUNT = 8,
  parameter logic [10:0] MODE_REG      = MODE_REG_DEFAULT
) (
  input  logic        clk112M,
  input  logic        reset_n,
  input  logic        sdram_init_n,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [10:0] sdram_addr,
  output logic        init_done
);

  localparam int RP_CYC  = ns_to_cycles(T_RP_NS, CLK);
  localparam int RFC_CYC = ns_to_cycles(T_RFC_NS, CLK);
  localparam int MAX_AB  = (RP_CYC > RFC_CYC) ? RP_CYC : RFC_CYC;
  localparam int MAX_CYC = (MAX_AB > T_MRD_CYC) ? MAX_AB : T_MRD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(RP_CYC - 1);
  localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'(RFC_CYC - 1);
  localparam logic [CNT_W-1:0] MRD_LOAD = CNT_W'(T_MRD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       REF_N    = 4'(REFRESH_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRECHARGE,
    S_WAIT_RP,
    S_REFRESH,
    S_WAIT_RFC,
    S_MRS,
    S_WAIT_MRD,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [3:0]       ref_q, ref_d;
  sdram_cmd_t       cmd_d;
  logic [10:0]      addr_d;

  always_ff @(posedge clk112M or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ref_q   <= ref_d;
    end
  end

  // A wait state of zero length is skipped by jumping straight to the
  // following command state; this matters when a timing rounds to 1 cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ref_d   = ref_q;
    if (sdram_init_n && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      wait_d  = '0;
      ref_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!sdram_init_n) state_d = S_PRECHARGE;
        end
        S_PRECHARGE: begin
          if (RP_CYC > 1) begin
            state_d = S_WAIT_RP;
            wait_d  = RP_LOAD;
          end else begin
            state_d = S_REFRESH;
          end
        end
        S_WAIT_RP: begin
          if (wait_q == CNT_ONE) begin
            wait_d  = '0;
            state_d = S_REFRESH;
          end else begin
            wait_d = wait_q - CNT_ONE;
          end
        end
        S_REFRESH: begin
          ref_d = ref_q + 4'd1;
          if (RFC_CYC > 1) begin
            state_d = S_WAIT_RFC;
            wait_d  = RFC_LOAD;
          end else begin
            state_d = (ref_d < REF_N) ? S_REFRESH : S_MRS;
          end
        end
        S_WAIT_RFC: begin
          if (wait_q == CNT_ONE) begin
            wait_d  = '0;
            state_d = (ref_q < REF_N) ? S_REFRESH : S_MRS;
          end else begin
            wait_d = wait_q - CNT_ONE;
          end
        end
        S_MRS: begin
          if (T_MRD_CYC > 1) begin
            state_d = S_WAIT_MRD;
            wait_d  = MRD_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
        S_WAIT_MRD: begin
          if (wait_q == CNT_ONE) begin
            wait_d  = '0;
            state_d = S_DONE;
          end else begin
            wait_d = wait_q - CNT_ONE;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so the command
  // appears on the pins in the same cycle the state is entered.
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    case (state_d)
      S_PRECHARGE: begin
        cmd_d  = CMD_PRECHARGE;
        addr_d = 11'h400;        // A10 high selects all banks
      end
      S_REFRESH: cmd_d = CMD_REFRESH;
      S_MRS: begin
        cmd_d  = CMD_MRS;
        addr_d = MODE_REG;
      end
      default: cmd_d = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk112M or negedge reset_n) begin
    if (!reset_n) begin
      sdram_cke  <= 1'b0;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= 4'b0111;
      sdram_ba   <= 2'b00;
      sdram_addr <= '0;
      init_done  <= 1'b0;
    end else begin
      sdram_cke  <= 1'b1;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= cmd_pins(cmd_d);
      sdram_ba   <= 2'b00;
      sdram_addr <= addr_d;
      init_done  <= (state_d == S_DONE);
    end
  end

endmodule

`default_nettype wire
